// File: rtl/fetch_pc_gen_if.sv
// Fetch-line request handshake between the PC generator and the I-Cache.
// master = PC generator, slave = I-Cache.
interface fetch_pc_gen_if #(
  parameter int unsigned INDEX_W = 12
);
  logic               inst_req;
  logic [INDEX_W-1:0] inst_index;
  logic               inst_index_ok;

  modport master (output inst_req, output inst_index, input inst_index_ok);
  modport slave  (input inst_req, input inst_index, output inst_index_ok);
endinterface

// File: rtl/fetch_pc_gen.sv
// IF-stage fetch-PC generator: redirect selection, delay-slot spill handling, alignment-fault hold.
// Optional performance counters enabled by defining FETCH_PC_GEN_PERF_EN.
module fetch_pc_gen #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned INDEX_W     = 12,
  parameter logic [31:0] START_PC    = 32'hBFC0_0000,
  parameter logic [4:0]  EXC_ADEL    = 5'h04,
  localparam int unsigned LW         = $clog2(FETCH_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_pc_gen_if.master         ic,
  input  logic                   stop_fetch_i,
  input  logic                   pred_taken_i,
  input  logic [31:0]            pred_target_i,
  input  logic [LW-1:0]          pred_br_lane_i,
  input  logic                   exc_redirect_i,
  input  logic [31:0]            exc_pc_i,
  input  logic                   br_flush_i,
  input  logic [31:0]            br_pc_i,
  input  logic                   diff_redirect_i,
  input  logic [31:0]            diff_pc_i,
  output logic [31:0]            vaddr_o,
  output logic [31:0]            line_base_o,
  output logic [FETCH_WIDTH-1:0] inst_enable_o,
  output logic                   need_dslot_o,
  output logic                   has_exc_o,
  output logic [4:0]             exc_code_o
`ifdef FETCH_PC_GEN_PERF_EN
  ,
  output logic [31:0]            perf_fire_cnt_o,
  output logic [31:0]            perf_redirect_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, DSLOT, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dslot_q, dslot_d;

  logic        fire;
  logic        redirect;
  logic        misaligned;
  logic [31:0] line_base;
  logic [31:0] next_line;
  logic [LW:0] lim;
  logic [LW:0] off;

  assign line_base  = {pc_q[31:LW+2], {(LW+2){1'b0}}};
  assign next_line  = line_base + 32'(FETCH_WIDTH * 4);
  assign misaligned = |pc_q[1:0];
  assign redirect   = exc_redirect_i | br_flush_i | diff_redirect_i;

  assign ic.inst_req   = rst & ~stop_fetch_i & (state_q != HALT);
  assign ic.inst_index = pc_q[INDEX_W-1:0];
  assign fire          = ic.inst_req & ic.inst_index_ok;

  assign vaddr_o      = pc_q;
  assign line_base_o  = line_base;
  assign need_dslot_o = (state_q == DSLOT);
  assign has_exc_o    = misaligned;
  assign exc_code_o   = misaligned ? EXC_ADEL : '0;

  // Last enabled lane is the branch lane plus its delay slot, clipped to the line end.
  always_comb begin
    off = {1'b0, pc_q[LW+1:2]};
    lim = {1'b0, pred_br_lane_i} + (LW+1)'(1);
    if (lim > (LW+1)'(FETCH_WIDTH - 1))
      lim = (LW+1)'(FETCH_WIDTH - 1);
    inst_enable_o = '0;
    if (state_q == DSLOT) begin
      inst_enable_o[0] = 1'b1;
    end else begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        inst_enable_o[i] = ((LW+1)'(i) >= off) &&
                           (!(state_q == RUN && pred_taken_i) || ((LW+1)'(i) <= lim));
      end
    end
  end

  // Fault entry outranks fire so the faulting PC stays visible while halted.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    dslot_d = dslot_q;
    if (redirect) begin
      state_d = RUN;
      dslot_d = '0;
      if (exc_redirect_i)  pc_d = exc_pc_i;
      else if (br_flush_i) pc_d = br_pc_i;
      else                 pc_d = diff_pc_i;
    end else if (state_q != HALT && misaligned) begin
      state_d = HALT;
    end else if (fire) begin
      unique case (state_q)
        RUN: begin
          if (!pred_taken_i) begin
            pc_d = next_line;
          end else if (pred_br_lane_i != LW'(FETCH_WIDTH - 1)) begin
            pc_d = pred_target_i;
          end else begin
            pc_d    = next_line;
            dslot_d = pred_target_i;
            state_d = DSLOT;
          end
        end
        DSLOT: begin
          pc_d    = dslot_q;
          dslot_d = '0;
          state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= START_PC;
      state_q <= RUN;
      dslot_q <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      dslot_q <= dslot_d;
    end
  end

`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0] fire_cnt_q;
  logic [31:0] redir_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_cnt_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (fire && fire_cnt_q != '1)      fire_cnt_q  <= fire_cnt_q + 32'd1;
      if (redirect && redir_cnt_q != '1) redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign perf_fire_cnt_o     = fire_cnt_q;
  assign perf_redirect_cnt_o = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen (FETCH_WIDTH=4, default parameters).
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop_fetch;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_lane;
  logic        exc_redir;
  logic [31:0] exc_pc;
  logic        br_flush;
  logic [31:0] br_pc;
  logic        diff_redir;
  logic [31:0] diff_pc;
  logic [31:0] vaddr;
  logic [31:0] line_base;
  logic [3:0]  en;
  logic        need_dslot;
  logic        has_exc;
  logic [4:0]  exc_code;
`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0] perf_fire;
  logic [31:0] perf_redir;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_gen_if #(.INDEX_W(12)) ic ();

  fetch_pc_gen #(
    .FETCH_WIDTH (4),
    .INDEX_W     (12),
    .START_PC    (32'hBFC0_0000),
    .EXC_ADEL    (5'h04)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ic              (ic),
    .stop_fetch_i    (stop_fetch),
    .pred_taken_i    (pred_taken),
    .pred_target_i   (pred_target),
    .pred_br_lane_i  (pred_lane),
    .exc_redirect_i  (exc_redir),
    .exc_pc_i        (exc_pc),
    .br_flush_i      (br_flush),
    .br_pc_i         (br_pc),
    .diff_redirect_i (diff_redir),
    .diff_pc_i       (diff_pc),
    .vaddr_o         (vaddr),
    .line_base_o     (line_base),
    .inst_enable_o   (en),
    .need_dslot_o    (need_dslot),
    .has_exc_o       (has_exc),
    .exc_code_o      (exc_code)
`ifdef FETCH_PC_GEN_PERF_EN
    ,
    .perf_fire_cnt_o     (perf_fire),
    .perf_redirect_cnt_o (perf_redir)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_br(input logic [31:0] target);
    br_flush = 1'b1;
    br_pc    = target;
    step();
    br_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; stop_fetch = 1'b0; pred_taken = 1'b0; pred_target = '0; pred_lane = '0;
    exc_redir = 1'b0; exc_pc = '0; br_flush = 1'b0; br_pc = '0; diff_redir = 1'b0; diff_pc = '0;
    ic.inst_index_ok = 1'b1;
    #2;
    step();
    n_checks++; if (vaddr !== 32'hBFC00000) begin n_fail++; $display("FAIL reset_vaddr got=%h exp=%h", vaddr, 32'hBFC00000); end
    n_checks++; if (ic.inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", ic.inst_req); end
    n_checks++; if ({need_dslot, has_exc, exc_code} !== 7'd0) begin n_fail++; $display("FAIL reset_flags got=%b%b%h exp=0", need_dslot, has_exc, exc_code); end
    n_checks++; if (en !== 4'b1111) begin n_fail++; $display("FAIL reset_en got=%b exp=1111", en); end
    rst = 1'b1;
    #1;
    n_checks++; if (ic.inst_req !== 1'b1) begin n_fail++; $display("FAIL run_req got=%b exp=1", ic.inst_req); end
    step();
    n_checks++; if (vaddr !== 32'hBFC00010) begin n_fail++; $display("FAIL seq1 got=%h exp=%h", vaddr, 32'hBFC00010); end
    n_checks++; if (en !== 4'b1111) begin n_fail++; $display("FAIL seq1_en got=%b exp=1111", en); end
    step();
    n_checks++; if (vaddr !== 32'hBFC00020) begin n_fail++; $display("FAIL seq2 got=%h exp=%h", vaddr, 32'hBFC00020); end
    n_checks++; if (ic.inst_index !== 12'h020) begin n_fail++; $display("FAIL seq2_index got=%h exp=020", ic.inst_index); end
  endtask

  task automatic test_br_flush();
    redirect_br(32'h80000008);
    n_checks++; if (vaddr !== 32'h80000008) begin n_fail++; $display("FAIL br_vaddr got=%h exp=%h", vaddr, 32'h80000008); end
    n_checks++; if (en !== 4'b1100) begin n_fail++; $display("FAIL br_en got=%b exp=1100", en); end
    n_checks++; if (line_base !== 32'h80000000) begin n_fail++; $display("FAIL br_line_base got=%h exp=%h", line_base, 32'h80000000); end
    step();
    n_checks++; if (vaddr !== 32'h80000010) begin n_fail++; $display("FAIL br_next got=%h exp=%h", vaddr, 32'h80000010); end
  endtask

  task automatic test_pred_same_line();
    redirect_br(32'h00001000);
    pred_taken = 1'b1; pred_lane = 2'd1; pred_target = 32'h00002004;
    #1;
    n_checks++; if (en !== 4'b0111) begin n_fail++; $display("FAIL pred_en got=%b exp=0111", en); end
    step();
    pred_taken = 1'b0;
    #1;
    n_checks++; if (vaddr !== 32'h00002004) begin n_fail++; $display("FAIL pred_target got=%h exp=%h", vaddr, 32'h00002004); end
    n_checks++; if (en !== 4'b1110) begin n_fail++; $display("FAIL pred_target_en got=%b exp=1110", en); end
  endtask

  task automatic test_dslot();
    redirect_br(32'h00001000);
    pred_taken = 1'b1; pred_lane = 2'd3; pred_target = 32'h00003000;
    #1;
    n_checks++; if (en !== 4'b1111) begin n_fail++; $display("FAIL dslot_pre_en got=%b exp=1111", en); end
    step();
    // Predictor inputs must be ignored while in DSLOT.
    pred_lane = 2'd0; pred_target = 32'h0000DEAD;
    #1;
    n_checks++; if (vaddr !== 32'h00001010) begin n_fail++; $display("FAIL dslot_vaddr got=%h exp=%h", vaddr, 32'h00001010); end
    n_checks++; if (need_dslot !== 1'b1) begin n_fail++; $display("FAIL dslot_flag got=%b exp=1", need_dslot); end
    n_checks++; if (en !== 4'b0001) begin n_fail++; $display("FAIL dslot_en got=%b exp=0001", en); end
    step();
    pred_taken = 1'b0;
    #1;
    n_checks++; if (vaddr !== 32'h00003000) begin n_fail++; $display("FAIL dslot_target got=%h exp=%h", vaddr, 32'h00003000); end
    n_checks++; if (need_dslot !== 1'b0) begin n_fail++; $display("FAIL dslot_exit got=%b exp=0", need_dslot); end
  endtask

  task automatic test_priority();
    exc_redir = 1'b1; exc_pc = 32'hBFC00380; br_flush = 1'b1; br_pc = 32'h00005000;
    step();
    exc_redir = 1'b0; br_flush = 1'b0;
    n_checks++; if (vaddr !== 32'hBFC00380) begin n_fail++; $display("FAIL prio_exc got=%h exp=%h", vaddr, 32'hBFC00380); end
    br_flush = 1'b1; br_pc = 32'h00005000; diff_redir = 1'b1; diff_pc = 32'h00007000;
    step();
    br_flush = 1'b0; diff_redir = 1'b0;
    n_checks++; if (vaddr !== 32'h00005000) begin n_fail++; $display("FAIL prio_br got=%h exp=%h", vaddr, 32'h00005000); end
    // Exception during DSLOT abandons the pending slot target.
    redirect_br(32'h00001000);
    pred_taken = 1'b1; pred_lane = 2'd3; pred_target = 32'h00003000;
    step();
    pred_taken = 1'b0;
    exc_redir = 1'b1; exc_pc = 32'h00006000;
    step();
    exc_redir = 1'b0;
    n_checks++; if (vaddr !== 32'h00006000 || need_dslot !== 1'b0) begin n_fail++; $display("FAIL dslot_abandon got=%h/%b exp=%h/0", vaddr, need_dslot, 32'h00006000); end
    step();
    n_checks++; if (vaddr !== 32'h00006010) begin n_fail++; $display("FAIL dslot_abandon_next got=%h exp=%h", vaddr, 32'h00006010); end
  endtask

  task automatic test_stall_and_wrap();
    stop_fetch = 1'b1;
    #1;
    n_checks++; if (ic.inst_req !== 1'b0) begin n_fail++; $display("FAIL stop_req got=%b exp=0", ic.inst_req); end
    step(); step();
    n_checks++; if (vaddr !== 32'h00006010) begin n_fail++; $display("FAIL stop_hold got=%h exp=%h", vaddr, 32'h00006010); end
    stop_fetch = 1'b0; ic.inst_index_ok = 1'b0;
    step();
    n_checks++; if (vaddr !== 32'h00006010) begin n_fail++; $display("FAIL nook_hold got=%h exp=%h", vaddr, 32'h00006010); end
    ic.inst_index_ok = 1'b1;
    redirect_br(32'hFFFFFFF4);
    step();
    n_checks++; if (vaddr !== 32'h00000000) begin n_fail++; $display("FAIL wrap got=%h exp=00000000", vaddr); end
  endtask

  task automatic test_misaligned_halt();
    diff_redir = 1'b1; diff_pc = 32'h00004002;
    step();
    diff_redir = 1'b0;
    n_checks++; if (has_exc !== 1'b1 || exc_code !== 5'h04) begin n_fail++; $display("FAIL adel_flag got=%b/%h exp=1/04", has_exc, exc_code); end
    n_checks++; if (ic.inst_req !== 1'b1) begin n_fail++; $display("FAIL adel_one_req got=%b exp=1", ic.inst_req); end
    step();
    n_checks++; if (ic.inst_req !== 1'b0) begin n_fail++; $display("FAIL halt_req got=%b exp=0", ic.inst_req); end
    step(); step(); step();
    n_checks++; if (ic.inst_req !== 1'b0 || vaddr !== 32'h00004002) begin n_fail++; $display("FAIL halt_hold got=%b/%h exp=0/%h", ic.inst_req, vaddr, 32'h00004002); end
    exc_redir = 1'b1; exc_pc = 32'hBFC00380;
    step();
    exc_redir = 1'b0;
    n_checks++; if (vaddr !== 32'hBFC00380 || ic.inst_req !== 1'b1 || has_exc !== 1'b0) begin n_fail++; $display("FAIL halt_exit got=%h/%b/%b exp=%h/1/0", vaddr, ic.inst_req, has_exc, 32'hBFC00380); end
    step();
    n_checks++; if (vaddr !== 32'hBFC00390) begin n_fail++; $display("FAIL halt_exit_next got=%h exp=%h", vaddr, 32'hBFC00390); end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (vaddr !== 32'hBFC00000) begin n_fail++; $display("FAIL async_rst got=%h exp=%h", vaddr, 32'hBFC00000); end
    step();
    rst = 1'b1;
    step();
    n_checks++; if (vaddr !== 32'hBFC00010) begin n_fail++; $display("FAIL async_rst_run got=%h exp=%h", vaddr, 32'hBFC00010); end
  endtask

  initial begin
    test_reset();
    test_br_flush();
    test_pred_same_line();
    test_dslot();
    test_priority();
    test_stall_and_wrap();
    test_misaligned_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
